// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display value/brightness in, segment/digit drive out for seg_scan_ctrl
interface seg_scan_ctrl_if #(parameter int NUM_DIGITS = 2);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] dp_in;
  logic load;
  logic [3:0] brightness;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] dig_en;
  logic frame_start;
  modport master(output value, dp_in, load, brightness, input seg, dp, dig_en, frame_start);
  modport slave(input value, dp_in, load, brightness, output seg, dp, dig_en, frame_start);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-seg scan with dead-time, PWM brightness, frame-synchronous update; SEG_SCAN_LZ_BLANK_EN enables leading-zero blanking
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 2,
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 4
) (
  input logic CLK,
  input logic rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int TW = $clog2(DWELL_CYCLES + BLANK_CYCLES + 1);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP = DWELL_CYCLES / 16;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  typedef enum logic {BLANK, SHOW} state_t;
  localparam state_t FIRST = BLANK_CYCLES == 0 ? SHOW : BLANK;
  state_t st, st_nx;
  logic [DW-1:0] dig, dig_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [4*NUM_DIGITS-1:0] sh_v, act_v, act_v_nx;
  logic [NUM_DIGITS-1:0] sh_dp, act_dp, act_dp_nx;
  logic [3:0] bri_q, bri_eff, nib;
  logic last, frame_edge, lit;
  logic [6:0] seg_q;
  logic dp_q, fs_q;
  logic [NUM_DIGITS-1:0] en_q;
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.dig_en = en_q;
  assign bus.frame_start = fs_q;
  // slot sequencing, frame-boundary value swap (with same-edge load bypass) and per-slot brightness latch
  always_comb begin
    last = st == SHOW ? tmr == TW'(DWELL_CYCLES - 1) : tmr == TW'(BLANK_CYCLES - 1);
    tmr_nx = last ? '0 : tmr + 1'b1;
    st_nx = !last ? st : st == BLANK ? SHOW : FIRST;
    dig_nx = (last && st == SHOW) ? (dig == DW'(NUM_DIGITS - 1) ? '0 : dig + 1'b1) : dig;
    frame_edge = st == FIRST && dig == '0 && tmr == '0;
    act_v_nx = !frame_edge ? act_v : bus.load ? bus.value : sh_v;
    act_dp_nx = !frame_edge ? act_dp : bus.load ? bus.dp_in : sh_dp;
    nib = act_v_nx[4*dig +: 4];
    bri_eff = (st == SHOW && tmr == '0) ? bus.brightness : bri_q;
`ifdef SEG_SCAN_LZ_BLANK_EN
    lit = st == SHOW && (dig == '0 || (act_v_nx >> (4*dig)) != '0 || act_dp_nx[dig]);
`else
    lit = st == SHOW;
`endif
  end
  // state, value registers and registered display outputs
  always_ff @(posedge CLK) begin
    if (rst) begin
      st <= FIRST;
      dig <= '0;
      tmr <= '0;
      sh_v <= '0;
      sh_dp <= '0;
      act_v <= '0;
      act_dp <= '0;
      bri_q <= '0;
      seg_q <= '0;
      dp_q <= 1'b0;
      en_q <= '0;
      fs_q <= 1'b0;
    end else begin
      st <= st_nx;
      dig <= dig_nx;
      tmr <= tmr_nx;
      if (bus.load) begin
        sh_v <= bus.value;
        sh_dp <= bus.dp_in;
      end
      act_v <= act_v_nx;
      act_dp <= act_dp_nx;
      bri_q <= bri_eff;
      seg_q <= lit ? GLYPH[nib] : '0;
      dp_q <= lit && act_dp_nx[dig];
      en_q <= (lit && 32'(tmr) < 32'(bri_eff) * STEP) ? NUM_DIGITS'(1) << dig : '0;
      fs_q <= frame_edge;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized bench against a frame-position reference model
module tb_seg_scan_ctrl;
  localparam int ND = 2, DWELL = 16, BL = 2, SLOT = BL + DWELL, FRAME = ND * SLOT;
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  logic CLK = 0, rst = 1;
  always #5 CLK = ~CLK;
  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();
  seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BL)) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );
  int n_cmp = 0, n_bad = 0, ncyc = 0, pos = 0, bri_held = 0, on_cnt = 0;
  logic [7:0] sh_v = 0, act_v = 0;
  logic [1:0] sh_dp = 0, act_dp = 0;
  logic [6:0] e_seg;
  logic e_dp, e_fs;
  logic [1:0] e_en;
  logic [3:0] bri = 15;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", tag, ncyc, got, exp);
    end
  endtask
  task automatic model();
    int d, off, t;
    bit lit;
    logic [3:0] nib;
    if (rst) begin
      pos = 0; sh_v = 0; sh_dp = 0; act_v = 0; act_dp = 0; bri_held = 0;
      e_seg = 0; e_dp = 0; e_en = 0; e_fs = 0;
    end else begin
      if (pos == 0) begin
        act_v = bus.load ? bus.value : sh_v;
        act_dp = bus.load ? bus.dp_in : sh_dp;
      end
      if (bus.load) begin
        sh_v = bus.value;
        sh_dp = bus.dp_in;
      end
      d = pos / SLOT;
      off = pos % SLOT;
      t = off - BL;
      lit = off >= BL;
      if (t == 0) bri_held = bus.brightness;
      nib = 4'(act_v >> (4 * d));
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (d > 0 && (act_v >> (4 * d)) == 0 && !act_dp[d]) lit = 0;
`endif
      e_fs = pos == 0;
      e_seg = lit ? GLYPH[nib] : 7'd0;
      e_dp = lit && act_dp[d];
      e_en = (lit && t < bri_held * (DWELL / 16)) ? 2'(1 << d) : 2'd0;
      pos = (pos + 1) % FRAME;
    end
  endtask
  task automatic step(input bit r, input bit ld, input logic [7:0] v, input logic [1:0] d, input logic [3:0] b);
    rst = r; bus.load = ld; bus.value = v; bus.dp_in = d; bus.brightness = b;
    @(posedge CLK);
    model();
    #1;
    ncyc++;
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("dig_en", 32'(bus.dig_en), 32'(e_en));
    check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    check("onehot", 32'($countones(bus.dig_en) <= 1), 32'd1);
    if (bus.dig_en[0]) on_cnt++;
  endtask
  initial begin
    repeat (3) step(1, 0, 8'h00, 2'b00, 15);
    for (int k = 0; k < 2 * FRAME; k++) step(0, k == 10, 8'h3A, 2'b10, 15);
    step(0, 1, 8'h7E, 2'b00, 15);
    repeat (FRAME - 1) step(0, 0, 8'h00, 2'b00, 15);
    repeat (FRAME) step(0, 0, 8'h00, 2'b00, 0);
    on_cnt = 0;
    repeat (FRAME) step(0, 0, 8'h00, 2'b00, 8);
    check("bri8_on_count", 32'(on_cnt), 32'd8);
    step(0, 1, 8'h05, 2'b00, 15);
    repeat (FRAME - 1) step(0, 0, 8'h00, 2'b00, 15);
    step(0, 1, 8'h00, 2'b00, 15);
    repeat (FRAME - 1) step(0, 0, 8'h00, 2'b00, 15);
    step(0, 1, 8'h92, 2'b11, 15);
    repeat (24) step(0, 0, 8'h00, 2'b00, 15);
    repeat (2) step(1, 0, 8'h00, 2'b00, 15);
    repeat (FRAME) step(0, 0, 8'h00, 2'b00, 15);
    for (int k = 0; k < 8 * FRAME; k++) begin
      if ($urandom_range(0, 40) == 0) bri = 4'($urandom);
      step($urandom_range(0, 300) == 0, $urandom_range(0, 24) == 0, 8'($urandom), 2'($urandom), bri);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
